// File: rtl/bkp_cfg_pkg.sv
// Shared definitions for the BkpCfg loader: command word layout, status word layout,
// loader FSM states and the latched command record.
package bkp_cfg_pkg;

  localparam int unsigned WORD_W        = 32;

  localparam int unsigned IDX_COMMIT    = 31;
  localparam int unsigned IDX_CLEAR_ALL = 30;
  localparam int unsigned IDX_CLR_ERR   = 29;
  localparam int unsigned IDX_ENTRY_LSB = 8;
  localparam int unsigned IDX_WORD_LSB  = 0;
  localparam int unsigned IDX_FIELD_W   = 8;

  localparam int unsigned ST_BUSY       = 0;
  localparam int unsigned ST_OVERRUN    = 1;
  localparam int unsigned ST_BAD_IDX    = 2;
  localparam int unsigned ST_CLEARING   = 3;
  localparam int unsigned ST_CNT_LSB    = 8;
  localparam int unsigned ST_LAST_LSB   = 16;
  localparam int unsigned ST_MASK_LSB   = 24;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_CLEAR  = 2'd2
  } state_e;

  typedef struct packed {
    logic                   commit;
    logic                   clear_all;
    logic                   clr_err;
    logic [IDX_FIELD_W-1:0] entry;
    logic [IDX_FIELD_W-1:0] word;
  } cmd_t;

endpackage

// File: rtl/bkp_rule_table.sv
// Rule table: data array (not reset), per-entry valid bits with set/clear ports,
// and a registered read port that returns pre-write contents on a same-cycle write.
module bkp_rule_table
  import bkp_cfg_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NWORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [WORD_W*NWORDS-1:0]   wdata_i,
  input  logic                       clr_i,
  input  logic [$clog2(DEPTH)-1:0]   clr_idx_i,
  input  logic                       rd_en_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic                       rd_valid_o,
  output logic                       rd_hit_o,
  output logic [WORD_W*NWORDS-1:0]   rd_data_o
);

  localparam int unsigned DW = WORD_W * NWORDS;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_hit_q, rd_hit_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;

  // Reads sample the current arrays, so a write in the same cycle is not seen.
  always_comb begin
    valid_d = valid_q;
    if (clr_i) valid_d[clr_idx_i] = 1'b0;
    if (we_i)  valid_d[waddr_i]   = 1'b1;
    rd_valid_d = rd_en_i;
    rd_hit_d   = rd_en_i ? valid_q[raddr_i] : rd_hit_q;
    rd_data_d  = rd_en_i ? mem_q[raddr_i]   : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      rd_valid_q <= rd_valid_d;
      rd_hit_q   <= rd_hit_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_hit_o   = rd_hit_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/bkp_cfg_loader.sv
// BkpCfg command loader: stages words into a shadow entry, commits whole entries into
// the rule table, sweeps valid bits on CLEAR_ALL and reports a registered status word.
module bkp_cfg_loader
  import bkp_cfg_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NWORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       BkpCfg_Ready_i,
  input  logic [31:0]                BkpCfg_DataIndex_i,
  input  logic [31:0]                BkpCfg_DataValue_i,
  output logic [31:0]                BK_Status_o,
  input  logic                       lkp_valid_i,
  input  logic [$clog2(DEPTH)-1:0]   lkp_entry_i,
  output logic                       lkp_valid_o,
  output logic                       lkp_hit_o,
  output logic [32*NWORDS-1:0]       lkp_data_o
);

  localparam int unsigned EW = $clog2(DEPTH);
  localparam int unsigned DW = WORD_W * NWORDS;

  state_e            state_q, state_d;
  logic              rdy_prev_q;
  cmd_t              cmd_q, cmd_d;
  logic [31:0]       val_q, val_d;
  logic [DW-1:0]     shadow_q, shadow_d;
  logic [NWORDS-1:0] mask_q, mask_d;
  logic              overrun_q, overrun_d;
  logic              bad_idx_q, bad_idx_d;
  logic [7:0]        commit_cnt_q, commit_cnt_d;
  logic [7:0]        last_entry_q, last_entry_d;
  logic [EW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [31:0]       status_q, status_d;
  logic              rdy_rise;
  logic              tbl_we, tbl_clr;
  logic              unused_idx_bits;

  // Reserved command bits carry no meaning.
  assign unused_idx_bits = ^BkpCfg_DataIndex_i[IDX_CLR_ERR-1:IDX_ENTRY_LSB+IDX_FIELD_W];

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    val_d        = val_q;
    shadow_d     = shadow_q;
    mask_d       = mask_q;
    overrun_d    = overrun_q;
    bad_idx_d    = bad_idx_q;
    commit_cnt_d = commit_cnt_q;
    last_entry_d = last_entry_q;
    clr_cnt_d    = clr_cnt_q;
    tbl_we       = 1'b0;
    tbl_clr      = 1'b0;
    rdy_rise     = BkpCfg_Ready_i & ~rdy_prev_q;

    case (state_q)
      S_IDLE: begin
        if (rdy_rise) begin
          cmd_d.commit    = BkpCfg_DataIndex_i[IDX_COMMIT];
          cmd_d.clear_all = BkpCfg_DataIndex_i[IDX_CLEAR_ALL];
          cmd_d.clr_err   = BkpCfg_DataIndex_i[IDX_CLR_ERR];
          cmd_d.entry     = BkpCfg_DataIndex_i[IDX_ENTRY_LSB +: IDX_FIELD_W];
          cmd_d.word      = BkpCfg_DataIndex_i[IDX_WORD_LSB +: IDX_FIELD_W];
          val_d           = BkpCfg_DataValue_i;
          state_d         = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        if (cmd_q.clear_all) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end else if (cmd_q.commit) begin
          if (9'(cmd_q.entry) >= 9'(DEPTH)) begin
            bad_idx_d = 1'b1;
          end else begin
            tbl_we       = 1'b1;
            mask_d       = '0;
            commit_cnt_d = commit_cnt_q + 8'd1;
            last_entry_d = cmd_q.entry;
          end
        end else if (cmd_q.clr_err) begin
          overrun_d = 1'b0;
          bad_idx_d = 1'b0;
        end else if (9'(cmd_q.word) >= 9'(NWORDS)) begin
          bad_idx_d = 1'b1;
        end else begin
          for (int unsigned w = 0; w < NWORDS; w++) begin
            if (cmd_q.word == 8'(w)) begin
              shadow_d[w*WORD_W +: WORD_W] = val_q;
              mask_d[w]                    = 1'b1;
            end
          end
        end
      end
      S_CLEAR: begin
        tbl_clr   = 1'b1;
        clr_cnt_d = clr_cnt_q + EW'(1);
        if (clr_cnt_q == EW'(DEPTH - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A strobe while a command is still in flight is lost; remember that it happened.
    if (rdy_rise && (state_q != S_IDLE)) overrun_d = 1'b1;

    // Built from next-state values so the status tracks the update cycle itself.
    status_d                           = '0;
    status_d[ST_BUSY]                  = (state_d != S_IDLE);
    status_d[ST_OVERRUN]               = overrun_d;
    status_d[ST_BAD_IDX]               = bad_idx_d;
    status_d[ST_CLEARING]              = (state_d == S_CLEAR);
    status_d[ST_CNT_LSB +: 8]          = commit_cnt_d;
    status_d[ST_LAST_LSB +: 8]         = last_entry_d;
    status_d[ST_MASK_LSB +: NWORDS]    = mask_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rdy_prev_q   <= 1'b0;
      cmd_q        <= '0;
      val_q        <= '0;
      shadow_q     <= '0;
      mask_q       <= '0;
      overrun_q    <= 1'b0;
      bad_idx_q    <= 1'b0;
      commit_cnt_q <= '0;
      last_entry_q <= '0;
      clr_cnt_q    <= '0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      rdy_prev_q   <= BkpCfg_Ready_i;
      cmd_q        <= cmd_d;
      val_q        <= val_d;
      shadow_q     <= shadow_d;
      mask_q       <= mask_d;
      overrun_q    <= overrun_d;
      bad_idx_q    <= bad_idx_d;
      commit_cnt_q <= commit_cnt_d;
      last_entry_q <= last_entry_d;
      clr_cnt_q    <= clr_cnt_d;
      status_q     <= status_d;
    end
  end

  assign BK_Status_o = status_q;

  bkp_rule_table #(
    .DEPTH  (DEPTH),
    .NWORDS (NWORDS)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .we_i       (tbl_we),
    .waddr_i    (cmd_q.entry[EW-1:0]),
    .wdata_i    (shadow_q),
    .clr_i      (tbl_clr),
    .clr_idx_i  (clr_cnt_q),
    .rd_en_i    (lkp_valid_i),
    .raddr_i    (lkp_entry_i),
    .rd_valid_o (lkp_valid_o),
    .rd_hit_o   (lkp_hit_o),
    .rd_data_o  (lkp_data_o)
  );

endmodule

// File: doc/bkp_cfg_loader.md
# bkp_cfg_loader

Consumes the BkpCfg command stream (ready/index/value) produced by the forwarder's AXI-lite control stage. It stages 32-bit words into a shadow entry and atomically commits whole entries into an on-chip rule table. It serves single-cycle-latency lookups to the forwarder datapath and returns a 32-bit status word that feeds the control stage's status input.

## Interface
- DEPTH, 16: number of rule-table entries; power of two, 2..256.
- NWORDS, 4: 32-bit words per entry; entry width is 32*NWORDS.
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous and active-high.
- BkpCfg_Ready_i  in  1  command strobe level. Each rising edge, relative to its previous sampled value, is one command.
- BkpCfg_DataIndex_i  in  32  command/address word.
- BkpCfg_DataValue_i  in  32  data word.
- BK_Status_o  out  32  status word, registered.
- lkp_valid_i  in  1  lookup request.
- lkp_entry_i  in  log2(DEPTH)  entry to read.
- lkp_valid_o  out  1  lookup response valid.
- lkp_hit_o  out  1  the entry's valid bit.
- lkp_data_o  out  32*NWORDS  entry contents.

## Operation
- DataIndex decode:
  - [31] COMMIT
  - [30] CLEAR_ALL
  - [29] CLR_ERR
  - [15:8] entry
  - [7:0] word
  - Priority: CLEAR_ALL > COMMIT > CLR_ERR > STAGE. STAGE means no command bit is set.
- STAGE:
  - Write Value into shadow word [word] and set the corresponding bit of stage_mask.
  - word ≥ NWORDS sets bad_idx (sticky) and changes nothing else.
- COMMIT:
  - Copy the shadow register to table[entry] and set valid[entry].
  - Clear stage_mask.
  - Increment commit_cnt (8-bit, wraps 255→0).
  - Set last_entry to entry.
  - entry ≥ DEPTH sets bad_idx and does not commit.
  - Unstaged shadow words keep their previous contents. Committing with a partial mask is legal.
- CLEAR_ALL: clear the valid bits one entry per cycle, index 0 to DEPTH-1. Table data is untouched.
- CLR_ERR: clear overrun and bad_idx.
- FSM states:
  - IDLE: on a Ready rising edge, latch Index and Value and go to DECODE.
  - DECODE: perform STAGE, COMMIT or CLR_ERR in this cycle and return to IDLE. CLEAR_ALL goes to CLEAR with the counter at 0.
  - CLEAR: clear valid[counter]. Go to IDLE after counter reaches DEPTH-1.
- A Ready rising edge in any state other than IDLE drops the command and sets overrun (sticky).
- Lookup:
  - A request in cycle N gives its response in cycle N+1, with lkp_valid_o set to the registered lkp_valid_i.
  - A request is accepted every cycle and is never stalled.
- BK_Status_o fields:
  - [0] busy (state≠IDLE)
  - [1] overrun
  - [2] bad_idx
  - [3] clearing
  - [7:4] 0
  - [15:8] commit_cnt
  - [23:16] last_entry
  - [23+NWORDS:24] stage_mask
  - remaining bits 0

## Timing
- Reset values:
  - All outputs 0.
  - valid[] all 0, shadow 0, stage_mask 0, commit_cnt 0.
  - FSM in IDLE.
  - The Ready edge-detector history is 0, so Ready held high at reset release counts as an edge in the first cycle.
- Command latency:
  - Ready rises (sampled) in cycle N → DECODE in N+1.
  - The table/shadow update is visible in N+2.
  - BK_Status_o reflects the update in N+2.
- Lookup and commit to the same entry in the same cycle: the response carries the pre-commit data and valid bit (read-before-write). A lookup in the next cycle sees the new data.
- CLEAR takes exactly DEPTH cycles. busy is 1 from N+1 through N+1+DEPTH.
- A lookup during CLEAR returns hit=1 for entries not yet cleared.
- Reset asserted mid-CLEAR or mid-DECODE aborts immediately to the reset values. The table data array is not reset.

## Structure
- Shared package bkp_cfg_pkg holds:
  - the DataIndex bit positions (COMMIT/CLEAR_ALL/CLR_ERR, entry/word fields)
  - the status field offsets
  - the FSM state enum
- One sub-module: bkp_rule_table. It contains the DEPTH×(32*NWORDS) data array, the valid bits, the write port, the clear port and the registered read port.

## Test plan
- Stage words 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444, then COMMIT entry 5; lookup entry 5 → hit=1, data={0x44444444,…,0x11111111}, status[15:8]=1, [23:16]=5.
- Staged word 7 (≥NWORDS) → status[2]=1, stage_mask unchanged; then CLR_ERR → status[2]=0.
- Second Ready edge one cycle after the first → second command dropped, status[1]=1, first command completes normally.
- Commit entries 0..15, then CLEAR_ALL with DEPTH=16 → busy held for 17 cycles; lookup of entry 15 at clear cycle 3 → hit=1, at the end → hit=0.
- Lookup and COMMIT of entry 2 in the same cycle → old data returned; next-cycle lookup → new data.
- 256 commits → commit_cnt wraps to 0; rst asserted mid-CLEAR → all outputs 0 and FSM in IDLE in the same cycle.
